shift_unit_seq: RTL
===================

# shift_unit_seq

Multi-cycle 32-bit shifter fed by the shift-amount multiplexer of the datapath. It consumes the 5-bit shift count N selected there (instruction shamt, register B[4:0], or the constant 16 for LUI), together with an operand and an operation code. It shifts one bit position per clock and reports completion with a single-cycle `done` pulse, which the control unit waits on before writing back `data_out`.

## Interface
- No parameters; width is fixed at 32 data bits and a 5-bit count.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  request strobe; sampled only in IDLE.
- `op`  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- `n`  in  5  shift count 0..31, from the shift-amount mux.
- `data_in`  in  32  operand.
- `data_out`  out  32  shift register contents; holds the result after `done`.
- `busy`  out  1  high while in SHIFT.
- `done`  out  1  one-cycle completion pulse.

## Operation
- Internal state: 32-bit shift register (drives `data_out`), 5-bit down-counter `cnt`, latched `op`, FSM {IDLE, SHIFT, DONE}.
- Reset (reset=0, any time, including mid-shift): state=IDLE, `data_out`=0, `cnt`=0, `busy`=0, `done`=0. No partial result is preserved.
- IDLE, start=1: load the register with `data_in`, `cnt`<=n, latch op. Go to SHIFT if n≠0, or directly to DONE if n=0.
- IDLE, start=0: hold. `data_out` keeps the last result.
- SHIFT: on each edge, shift the register by one bit per the latched op and decrement `cnt`. When the edge shifts with `cnt`=1, go to DONE.
  - SLL: {r[30:0],0}
  - SRL: {0,r[31:1]}
  - SRA: {r[31],r[31:1]}
  - ROR: {r[0],r[31:1]}
- DONE: `done`=1 for this one cycle. Unconditionally return to IDLE on the next edge.
- `start` in SHIFT or DONE is ignored; no queuing. `n`, `op` and `data_in` changes after the sampling edge have no effect.
- The result equals the single-step 32-bit shift by N. No wider arithmetic; bits shifted out are discarded, except under ROR.

## Timing
- Let edge k be the edge that samples start=1 in IDLE.
- `done` is high during the cycle following edge k+N. For N=0, that is the cycle right after edge k.
- `busy` is high from after edge k to after edge k+N−1, for N≥1. `busy` is never high for N=0.
- `data_out` is valid, equal to the final result, from edge k+N onward, stable until the next accepted start.
- The earliest next accepted start is sampled at edge k+N+2, since `start` is ignored while in DONE. Back-to-back throughput is one operation per N+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `SHIFT_ROT_EN`
  - Defined: op=11 performs rotate-right by N, as above.
  - Undefined: the ROR logic is omitted. op=11 still runs the full N-cycle sequence, but the register is left unchanged (result = `data_in`), with identical `busy`/`done` timing.

## Test plan
- SLL: data_in=0x0000_0001, n=16, op=00 → `data_out`=0x0001_0000. `done` high in the cycle after edge k+16; `busy` high for 16 cycles.
- SRA and SRL: data_in=0x8000_0000, n=4, op=10 → 0xF800_0000. The same operand with n=31, op=01 → 0x0000_0001.
- Zero count: data_in=0xDEAD_BEEF, n=0, op=00 → `data_out`=0xDEAD_BEEF. `done` in the cycle after edge k; `busy` never asserted.
- ROR: data_in=0x0000_0001, n=1, op=11 → 0x8000_0000 with `SHIFT_ROT_EN` defined. Without the macro → 0x0000_0001, with the same `done` timing.
- Ignored start: start SLL n=8 on 0x0000_00FF. Pulse start with n=1, data_in=0 during SHIFT and again during DONE → result is 0x0000_FF00, `done` pulses exactly once, and the FSM returns to IDLE.
- Reset mid-operation: start SRL n=20. Drive reset low asynchronously at edge k+5 plus half a cycle → `data_out`=0, `busy`=0, `done`=0 immediately. After release, a new SLL n=1 on 0x1 yields 0x2.

Source files
------------

// File: rtl/shift_unit_seq.sv
// Multi-cycle 32-bit shifter: one bit position per clock, single-cycle done pulse.
// Optional macro SHIFT_ROT_EN enables rotate-right for op=11; otherwise op=11 leaves the operand unchanged.
module shift_unit_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [4:0]  n,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]  state_reg;
  logic [31:0] shreg_reg;
  logic [31:0] shreg_next;
  logic [4:0]  cnt_reg;
  logic [1:0]  op_reg;
  logic        busy_reg;
  logic        done_reg;

  always_comb begin
    shreg_next = shreg_reg;
    case (op_reg)
      2'b00:   shreg_next = {shreg_reg[30:0], 1'b0};
      2'b01:   shreg_next = {1'b0, shreg_reg[31:1]};
      2'b10:   shreg_next = {shreg_reg[31], shreg_reg[31:1]};
      default: begin
`ifdef SHIFT_ROT_EN
        shreg_next = {shreg_reg[0], shreg_reg[31:1]};
`else
        shreg_next = shreg_reg;
`endif
      end
    endcase
  end

  // busy/done are kept as their own flops so every output comes straight from a register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
      shreg_reg <= 32'd0;
      cnt_reg   <= 5'd0;
      op_reg    <= 2'b00;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            shreg_reg <= data_in;
            cnt_reg   <= n;
            op_reg    <= op;
            busy_reg  <= (n != 5'd0);
            done_reg  <= (n == 5'd0);
            state_reg <= (n == 5'd0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          shreg_reg <= shreg_next;
          cnt_reg   <= cnt_reg - 5'd1;
          if (cnt_reg == 5'd1) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
            state_reg <= S_DONE;
          end
        end
        S_DONE: begin
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign data_out = shreg_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;

endmodule
